program_loader: RTL and testbench

- Boot-time loader that sits directly upstream of the RAM write port and fills main memory from an 8-bit byte stream (host link, ROM dump, or testbench).
- Parses a 4-byte header (origin, word count), then assembles data words from byte pairs and issues one single-cycle RAM write per word.
- While the loader is busy, the integrator muxes its RAM outputs over the CPU's outputs, and the CPU is held.

---
 rtl/program_loader_pkg.sv | 29 ++
 rtl/program_loader.sv | 183 ++++++++++++++++++
 tb/tb_program_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader.
//   loader_state_e : FSM state encoding
//   BYTE_WIDTH     : width of the incoming stream byte
//   HEADER_BYTES   : origin (2 bytes) + word count (2 bytes)
package program_loader_pkg;

   localparam int BYTE_WIDTH   = 8;
   localparam int HEADER_BYTES = 4;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      ORG_LO  = 4'd1,
      ORG_HI  = 4'd2,
      CNT_LO  = 4'd3,
      CNT_HI  = 4'd4,
      DATA_LO = 4'd5,
      DATA_HI = 4'd6,
      WRITE   = 4'd7,
      DONE    = 4'd8,
      ERROR   = 4'd9
   } loader_state_e;

   // States in which the loader consumes a stream byte.
   function automatic logic is_receiving(input loader_state_e s);
      return (s == ORG_LO) || (s == ORG_HI) || (s == CNT_LO) ||
             (s == CNT_HI) || (s == DATA_LO) || (s == DATA_HI);
   endfunction

endpackage

// File: rtl/program_loader.sv
// Boot-time program loader. Parses a little-endian header (origin, word
// count) from an 8-bit byte stream, then assembles data words from byte
// pairs and issues one single-cycle RAM write per word.
//
// Ports:
//   clock, reset            : system clock, async active-high reset
//   start_in                : pulse, begins a session (from IDLE or ERROR)
//   abort_in                : ends any session on the next edge
//   byte_in, byte_valid_in  : stream byte and its valid
//   byte_ready_out          : loader accepts byte_in this cycle
//   ram_address_out/_data_out/_write_enable_out : RAM write port
//   busy_out                : session in progress (CPU held, RAM muxed)
//   done_out                : one-cycle pulse on successful completion
//   error_out               : high while in ERROR
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for start_in
// ORG_LO  | receiving origin low byte
// ORG_HI  | receiving origin high byte
// CNT_LO  | receiving count low byte
// CNT_HI  | receiving count high byte, then range checks
// DATA_LO | receiving data word low byte
// DATA_HI | receiving data word high byte
// WRITE   | one-cycle RAM write strobe, pointer/count update
// DONE    | one-cycle completion pulse
// ERROR   | bad header; waits for start_in or abort_in
module program_loader
   import program_loader_pkg::*;
#(
   parameter int D_WIDTH = 16,
   parameter int A_WIDTH = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start_in,
   input  logic                  abort_in,
   input  logic [BYTE_WIDTH-1:0] byte_in,
   input  logic                  byte_valid_in,
   output logic                  byte_ready_out,
   output logic [A_WIDTH-1:0]    ram_address_out,
   output logic [D_WIDTH-1:0]    ram_data_out,
   output logic                  ram_write_enable_out,
   output logic                  busy_out,
   output logic                  done_out,
   output logic                  error_out
);

   // Number of RAM words; 17 bits so that a 16-bit address space fits.
   localparam logic [16:0] MEM_WORDS = 17'(1) << A_WIDTH;

   loader_state_e          state_q, state_d;
   logic [15:0]            origin_q, origin_d;
   logic [BYTE_WIDTH-1:0]  byte_q, byte_d;
   logic [A_WIDTH-1:0]     ptr_q, ptr_d;
   logic [16:0]            remaining_q, remaining_d;
   logic [A_WIDTH-1:0]     addr_q, addr_d;
   logic [D_WIDTH-1:0]     data_q, data_d;

   logic                   xfer;
   logic [16:0]            count_w;
   logic [16:0]            room_w;
   logic                   origin_oob;
   logic [15:0]            word_w;

   assign byte_ready_out = is_receiving(state_q) && !abort_in;
   assign xfer           = byte_valid_in && byte_ready_out;

   // Header checks use the count byte arriving now plus the latched low byte.
   assign count_w    = {1'b0, byte_in, byte_q};
   assign room_w     = MEM_WORDS - 17'(origin_q[A_WIDTH-1:0]);
   assign origin_oob = (origin_q >> A_WIDTH) != 16'd0;
   assign word_w     = {byte_in, byte_q};

   always_comb begin
      state_d     = state_q;
      origin_d    = origin_q;
      byte_d      = byte_q;
      ptr_d       = ptr_q;
      remaining_d = remaining_q;
      addr_d      = addr_q;
      data_d      = data_q;

      if (abort_in) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_in) state_d = ORG_LO;
            end
            ORG_LO: begin
               if (xfer) begin
                  origin_d[7:0] = byte_in;
                  state_d       = ORG_HI;
               end
            end
            ORG_HI: begin
               if (xfer) begin
                  origin_d[15:8] = byte_in;
                  state_d        = CNT_LO;
               end
            end
            CNT_LO: begin
               if (xfer) begin
                  byte_d  = byte_in;
                  state_d = CNT_HI;
               end
            end
            CNT_HI: begin
               if (xfer) begin
                  if (origin_oob || (count_w > room_w)) begin
                     state_d = ERROR;
                  end else if (count_w == 17'd0) begin
                     state_d = DONE;
                  end else begin
                     ptr_d       = origin_q[A_WIDTH-1:0];
                     remaining_d = count_w;
                     state_d     = DATA_LO;
                  end
               end
            end
            DATA_LO: begin
               if (xfer) begin
                  byte_d  = byte_in;
                  state_d = DATA_HI;
               end
            end
            DATA_HI: begin
               if (xfer) begin
                  // Address/data registers feed the RAM port directly and
                  // keep their value after the strobe.
                  addr_d  = ptr_q;
                  data_d  = word_w[D_WIDTH-1:0];
                  state_d = WRITE;
               end
            end
            WRITE: begin
               ptr_d       = ptr_q + A_WIDTH'(1);
               remaining_d = remaining_q - 17'd1;
               state_d     = (remaining_q == 17'd1) ? DONE : DATA_LO;
            end
            DONE: begin
               state_d = IDLE;
            end
            ERROR: begin
               if (start_in) state_d = ORG_LO;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         origin_q    <= '0;
         byte_q      <= '0;
         ptr_q       <= '0;
         remaining_q <= '0;
         addr_q      <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         origin_q    <= origin_d;
         byte_q      <= byte_d;
         ptr_q       <= ptr_d;
         remaining_q <= remaining_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
      end
   end

   // Abort suppresses the strobe in the same cycle so no partial word lands.
   assign ram_write_enable_out = (state_q == WRITE) && !abort_in;
   assign ram_address_out      = addr_q;
   assign ram_data_out         = data_q;
   assign busy_out             = (state_q != IDLE) && (state_q != DONE);
   assign done_out             = (state_q == DONE);
   assign error_out            = (state_q == ERROR);

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

   logic        clock = 1'b0;
   logic        reset;
   logic        start_in;
   logic        abort_in;
   logic [7:0]  byte_in;
   logic        byte_valid_in;
   logic        byte_ready_out;
   logic [11:0] ram_address_out;
   logic [15:0] ram_data_out;
   logic        ram_write_enable_out;
   logic        busy_out;
   logic        done_out;
   logic        error_out;

   int n_checks = 0;
   int n_errors = 0;

   // monitor state (written only by the monitor process)
   logic [15:0] ram [4096];
   logic [11:0] wr_addr [$];
   logic [15:0] wr_data [$];
   int          done_cnt = 0;
   int          busy_at_done = 0;
   int          ready_in_write = 0;

   program_loader #(.D_WIDTH(16), .A_WIDTH(12)) dut (
      .clock                (clock),
      .reset                (reset),
      .start_in             (start_in),
      .abort_in             (abort_in),
      .byte_in              (byte_in),
      .byte_valid_in        (byte_valid_in),
      .byte_ready_out       (byte_ready_out),
      .ram_address_out      (ram_address_out),
      .ram_data_out         (ram_data_out),
      .ram_write_enable_out (ram_write_enable_out),
      .busy_out             (busy_out),
      .done_out             (done_out),
      .error_out            (error_out)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (ram_write_enable_out) begin
         wr_addr.push_back(ram_address_out);
         wr_data.push_back(ram_data_out);
         ram[ram_address_out] = ram_data_out;
         if (byte_ready_out) ready_in_write++;
      end
      if (done_out) begin
         done_cnt++;
         if (busy_out) busy_at_done++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_start();
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok = 1'b0;
      repeat (gap) tick();
      byte_in       = b;
      byte_valid_in = 1'b1;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clock);
         if (byte_ready_out) ok = 1'b1;
         tick();
      end
      byte_valid_in = 1'b0;
      if (!ok) check_eq("byte_accept_timeout", 32'(ok), 32'd1);
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int n = 0; n < 60 && !seen; n++) begin
         @(negedge clock);
         if (!busy_out) seen = 1'b1;
      end
      check_eq(tag, 32'(seen), 32'd1);
      tick();
   endtask

   logic [7:0] basic_bytes [10] = '{8'h00, 8'h01, 8'h03, 8'h00,
                                    8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
   int         gaps        [10] = '{0, 2, 1, 0, 3, 0, 1, 2, 0, 4};
   logic [11:0] exp_addr   [3]  = '{12'h100, 12'h101, 12'h102};
   logic [15:0] exp_data   [3]  = '{16'h1234, 16'h5678, 16'h9ABC};

   initial begin
      int base;
      int d0;
      reset         = 1'b1;
      start_in      = 1'b0;
      abort_in      = 1'b0;
      byte_in       = 8'h00;
      byte_valid_in = 1'b0;
      foreach (ram[i]) ram[i] = 16'h0;
      #1;
      check_eq("rst_busy",  32'(busy_out), 0);
      check_eq("rst_done",  32'(done_out), 0);
      check_eq("rst_error", 32'(error_out), 0);
      check_eq("rst_we",    32'(ram_write_enable_out), 0);
      check_eq("rst_addr",  32'(ram_address_out), 0);
      check_eq("rst_data",  32'(ram_data_out), 0);
      check_eq("rst_ready", 32'(byte_ready_out), 0);
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // basic load
      base = wr_addr.size(); d0 = done_cnt;
      pulse_start();
      check_eq("basic_busy", 32'(busy_out), 1);
      foreach (basic_bytes[i]) send_byte(basic_bytes[i], 0);
      wait_done("basic_done_timeout");
      check_eq("basic_nwr", 32'(wr_addr.size() - base), 3);
      for (int i = 0; i < 3; i++) begin
         if (wr_addr.size() > base + i) begin
            check_eq("basic_addr", 32'(wr_addr[base+i]), 32'(exp_addr[i]));
            check_eq("basic_data", 32'(wr_data[base+i]), 32'(exp_data[i]));
         end
         check_eq("basic_ram", 32'(ram[exp_addr[i]]), 32'(exp_data[i]));
      end
      check_eq("basic_done_cnt", 32'(done_cnt - d0), 1);
      check_eq("basic_busy_at_done", 32'(busy_at_done), 0);
      check_eq("basic_idle_busy", 32'(busy_out), 0);

      // zero count
      base = wr_addr.size(); d0 = done_cnt;
      pulse_start();
      send_byte(8'h10, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      wait_done("zero_done_timeout");
      check_eq("zero_nwr", 32'(wr_addr.size() - base), 0);
      check_eq("zero_done_cnt", 32'(done_cnt - d0), 1);
      check_eq("zero_ready_after", 32'(byte_ready_out), 0);

      // range error: origin 0xF00, count 0x101 exceeds 0x100 words of room
      base = wr_addr.size(); d0 = done_cnt;
      pulse_start();
      send_byte(8'h00, 0); send_byte(8'h0F, 0); send_byte(8'h01, 0); send_byte(8'h01, 0);
      check_eq("err_flag", 32'(error_out), 1);
      check_eq("err_busy", 32'(busy_out), 1);
      check_eq("err_ready", 32'(byte_ready_out), 0);
      repeat (3) tick();
      check_eq("err_hold", 32'(error_out), 1);
      pulse_start();
      check_eq("err_cleared", 32'(error_out), 0);
      check_eq("err_restart_ready", 32'(byte_ready_out), 1);
      abort_in = 1'b1;
      #1;
      check_eq("abort_gates_ready", 32'(byte_ready_out), 0);
      tick();
      abort_in = 1'b0;
      check_eq("err_abort_idle", 32'(busy_out), 0);
      check_eq("err_nwr", 32'(wr_addr.size() - base), 0);
      check_eq("err_no_done", 32'(done_cnt - d0), 0);

      // top of memory
      base = wr_addr.size(); d0 = done_cnt;
      pulse_start();
      send_byte(8'hFF, 0); send_byte(8'h0F, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'hEF, 0); send_byte(8'hBE, 0);
      wait_done("top_done_timeout");
      check_eq("top_nwr", 32'(wr_addr.size() - base), 1);
      if (wr_addr.size() > base) begin
         check_eq("top_addr", 32'(wr_addr[base]), 32'h0FFF);
         check_eq("top_data", 32'(wr_data[base]), 32'hBEEF);
      end
      check_eq("top_done_cnt", 32'(done_cnt - d0), 1);

      // basic load with gaps in byte_valid_in
      foreach (exp_addr[i]) ram[exp_addr[i]] = 16'h0;
      base = wr_addr.size(); d0 = done_cnt;
      pulse_start();
      foreach (basic_bytes[i]) send_byte(basic_bytes[i], gaps[i]);
      wait_done("gap_done_timeout");
      check_eq("gap_nwr", 32'(wr_addr.size() - base), 3);
      for (int i = 0; i < 3; i++) begin
         if (wr_addr.size() > base + i) begin
            check_eq("gap_addr", 32'(wr_addr[base+i]), 32'(exp_addr[i]));
            check_eq("gap_data", 32'(wr_data[base+i]), 32'(exp_data[i]));
         end
      end
      check_eq("gap_done_cnt", 32'(done_cnt - d0), 1);
      check_eq("ready_low_in_write", 32'(ready_in_write), 0);

      // abort after the low byte of word 2
      base = wr_addr.size(); d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 7; i++) send_byte(basic_bytes[i], 0);
      abort_in = 1'b1;
      tick();
      abort_in = 1'b0;
      check_eq("abort_idle", 32'(busy_out), 0);
      repeat (3) tick();
      check_eq("abort_nwr", 32'(wr_addr.size() - base), 1);
      if (wr_addr.size() > base) begin
         check_eq("abort_addr", 32'(wr_addr[base]), 32'h100);
         check_eq("abort_data", 32'(wr_data[base]), 32'h1234);
      end
      check_eq("abort_no_done", 32'(done_cnt - d0), 0);

      // abort during WRITE suppresses the strobe
      base = wr_addr.size(); d0 = done_cnt;
      pulse_start();
      send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'hAA, 0); send_byte(8'hBB, 0);
      abort_in = 1'b1;
      #1;
      check_eq("abort_write_we", 32'(ram_write_enable_out), 0);
      tick();
      abort_in = 1'b0;
      repeat (2) tick();
      check_eq("abort_write_nwr", 32'(wr_addr.size() - base), 0);
      check_eq("abort_write_no_done", 32'(done_cnt - d0), 0);
      check_eq("abort_write_idle", 32'(busy_out), 0);

      // reset asserted during WRITE
      base = wr_addr.size(); d0 = done_cnt;
      pulse_start();
      send_byte(8'h00, 0); send_byte(8'h03, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0);
      check_eq("pre_rst_addr", 32'(ram_address_out), 32'h300);
      reset = 1'b1;
      #1;
      check_eq("rstw_we",   32'(ram_write_enable_out), 0);
      check_eq("rstw_addr", 32'(ram_address_out), 0);
      check_eq("rstw_data", 32'(ram_data_out), 0);
      check_eq("rstw_busy", 32'(busy_out), 0);
      tick();
      reset = 1'b0;
      repeat (2) tick();
      check_eq("rstw_nwr", 32'(wr_addr.size() - base), 0);
      check_eq("rstw_no_done", 32'(done_cnt - d0), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
